xdisp_scan: RTL

Four-digit seven-segment display scanner. It sits directly downstream of the picoVersat core in `xtop` as a memory-mapped peripheral, and is the block that drives the board's `Disp` segment bus and `Disp_sel` digit enables. The core writes digit values and control bits over the peripheral bus. The block stores them, decodes hex to segments and time-multiplexes the four digits, with a programmable blanking gap between digits to suppress ghosting.

---
 rtl/xdisp_scan.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/xdisp_scan.sv
// rtl/xdisp_scan.sv - four-digit seven-segment scanner with memory-mapped digit/control registers
module xdisp_scan #(
   parameter int DATA_W      = 32,
   parameter int REFRESH_DIV = 100000,
   parameter int BLANK_CYC   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sel,
   input  logic              we,
   input  logic [2:0]        addr,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic [7:0]        Disp,
   output logic [3:0]        Disp_sel
);

   localparam int CNT_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam int SHOW_CYC = REFRESH_DIV - BLANK_CYC;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

   typedef enum logic {S_SHOW, S_BLANK} state_t;

   logic [3:0]        dig_val   [4];
   logic              dig_dp    [4];
   logic              dig_blank [4];
   logic              en;

   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_inc;
   logic [1:0]        idx;
   state_t            state;

   logic [DATA_W-1:0] rd_data;
   logic              wr_en;
   logic              rd_en;
   logic              unused_data_hi;

   assign wr_en          = sel & we;
   assign rd_en          = sel & ~we;
   assign cnt_inc        = cnt + CNT_W'(1);
   assign unused_data_hi = ^data_in[DATA_W-1:16];

   // Hex nibble to active-low g..a segments
   function automatic logic [6:0] hex_seg(input logic [3:0] v);
      case (v)
         4'h0:    hex_seg = 7'h40;
         4'h1:    hex_seg = 7'h79;
         4'h2:    hex_seg = 7'h24;
         4'h3:    hex_seg = 7'h30;
         4'h4:    hex_seg = 7'h19;
         4'h5:    hex_seg = 7'h12;
         4'h6:    hex_seg = 7'h02;
         4'h7:    hex_seg = 7'h78;
         4'h8:    hex_seg = 7'h00;
         4'h9:    hex_seg = 7'h10;
         4'hA:    hex_seg = 7'h08;
         4'hB:    hex_seg = 7'h03;
         4'hC:    hex_seg = 7'h46;
         4'hD:    hex_seg = 7'h21;
         4'hE:    hex_seg = 7'h06;
         default: hex_seg = 7'h0E;
      endcase
   endfunction

   // Register writes: per-digit fields, enable, and packed nibble load that keeps dp/blank
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 4; i++) begin
            dig_val[i]   <= 4'h0;
            dig_dp[i]    <= 1'b0;
            dig_blank[i] <= 1'b0;
         end
         en <= 1'b0;
      end else if (wr_en) begin
         case (addr)
            3'd0, 3'd1, 3'd2, 3'd3: begin
               dig_val[addr[1:0]]   <= data_in[3:0];
               dig_dp[addr[1:0]]    <= data_in[4];
               dig_blank[addr[1:0]] <= data_in[5];
            end
            3'd4: en <= data_in[0];
            3'd5: begin
               for (int i = 0; i < 4; i++) begin
                  dig_val[i] <= data_in[4*i +: 4];
               end
            end
            default: ;
         endcase
      end
   end

   // Read mux; unimplemented bits and address 7 read as zero
   always_comb begin
      rd_data = '0;
      case (addr)
         3'd0, 3'd1, 3'd2, 3'd3:
            rd_data[5:0] = {dig_blank[addr[1:0]], dig_dp[addr[1:0]], dig_val[addr[1:0]]};
         3'd4: rd_data[0]    = en;
         3'd5: rd_data[15:0] = {dig_val[3], dig_val[2], dig_val[1], dig_val[0]};
         3'd6: rd_data[2:0]  = {(state == S_BLANK), idx};
         default: ;
      endcase
   end

   // Read data is captured on the read edge and held until the next read
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_out <= '0;
      end else if (rd_en) begin
         data_out <= rd_data;
      end
   end

   // Scan FSM: prescaler, digit index, SHOW/BLANK phase, and registered segment/digit drive
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt      <= '0;
         idx      <= 2'd0;
         state    <= S_SHOW;
         Disp     <= 8'hFF;
         Disp_sel <= 4'hF;
      end else begin
         // Outputs follow the current scan state and current register contents,
         // so a digit rewrite shows on the very next edge
         if (!en || state == S_BLANK) begin
            Disp     <= 8'hFF;
            Disp_sel <= 4'hF;
         end else begin
            Disp_sel <= ~(4'b0001 << idx);
            Disp     <= dig_blank[idx] ? 8'hFF : {~dig_dp[idx], hex_seg(dig_val[idx])};
         end

         if (!en) begin
            cnt   <= '0;
            idx   <= 2'd0;
            state <= S_SHOW;
         end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            idx   <= idx + 2'd1;
            state <= S_SHOW;
         end else begin
            cnt   <= cnt_inc;
            state <= (int'(cnt_inc) >= SHOW_CYC) ? S_BLANK : S_SHOW;
         end
      end
   end

endmodule
